fetch_unit: RTL

//   Instruction-fetch stage controller. Owns the fetch PC and the next-PC selection
//   (sequential / redirect), and drives requests to instruction memory over a req/ready handshake.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its surroundings: hazard/redirect inputs,
// the instruction-memory req/ready channel and the IF/ID register outputs.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;

  // imem channel: a word moves when imem_req && imem_ready; once imem_req rises,
  // imem_req and imem_addr hold until that transfer (the request is never withdrawn).
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
    output imem_req, imem_addr, pc_out, ifid_valid, ifid_pc, ifid_pc4, ifid_instr
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, pc_out, ifid_valid, ifid_pc, ifid_pc4, ifid_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the fetch PC, issues imem requests and loads the
// IF/ID register through a one-entry skid buffer that absorbs decode stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus,
  output logic         state_dbg_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_DISCARD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic        req;
  logic        xfer;
  logic [31:0] redir_pc;

  // DISCARD must keep its request up to drain the stale in-flight word.
  assign req      = reset & ((state_q == ST_DISCARD) | ~buf_valid_q);
  assign xfer     = req & bus.imem_ready;
  assign redir_pc = bus.redirect_pc & ~32'h0000_0003;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    buf_valid_d  = buf_valid_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;

    if (bus.redirect_valid) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      buf_valid_d  = 1'b0;
      if (req && !bus.imem_ready) begin
        tgt_d   = redir_pc;
        state_d = ST_DISCARD;
      end else begin
        pc_d    = redir_pc;
        state_d = ST_RUN;
      end
    end else if (state_q == ST_DISCARD) begin
      if (xfer) begin
        pc_d    = tgt_q;
        state_d = ST_RUN;
      end
    end else if (xfer) begin
      pc_d = pc_q + 32'd4;
      if (bus.stall) begin
        buf_valid_d = 1'b1;
        buf_pc_d    = pc_q;
        buf_instr_d = bus.imem_rdata;
      end else begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_q + 32'd4;
        ifid_instr_d = bus.imem_rdata;
      end
    end else if (buf_valid_q) begin
      if (!bus.stall) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = buf_pc_q;
        ifid_pc4_d   = buf_pc_q + 32'd4;
        ifid_instr_d = buf_instr_q;
        buf_valid_d  = 1'b0;
      end
    end else if (!bus.stall) begin
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      tgt_q        <= RESET_PC;
      buf_valid_q  <= 1'b0;
      buf_pc_q     <= 32'h0;
      buf_instr_q  <= 32'h0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      buf_valid_q  <= buf_valid_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.pc_out     = pc_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_pc4   = ifid_pc4_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign state_dbg_o    = (state_q == ST_DISCARD);

endmodule
